card_pixel_renderer: RTL and testbench
======================================

# card_pixel_renderer

Parametrised per-pixel card renderer for the VGA datapath. For each valid card-local pixel it produces an address into the card-background ROM and an address into the glyph ROM. It realigns all side-band data to the ROM read latency, then composes one 24-bit RGB pixel: background, saturating glyph overlay, optional dimming, then an optional flashing highlight border. It sits between the screen-region decoder (which supplies card-local coordinates) and the frame compositor, and it generalises card geometry, type count, glyph set and ROM latency.

## Interface
Parameters:
- CARD_W, 54, card width in pixels
- CARD_H, 68, card height in pixels
- NUM_TYPES, 4, number of background images stacked in the background ROM
- GLYPH_W, 22, glyph width in pixels
- GLYPH_H, 40, glyph height in pixels
- GLYPH_X0, 16, glyph window left column (card-local)
- GLYPH_Y0, 0, glyph window top row (card-local)
- NUM_GLYPHS, 10, number of glyphs in the glyph ROM
- OVERLAY_TYPE_MAX, 2, highest card_type that receives a glyph overlay
- MEM_LAT, 2, read latency of both ROMs in cycles (≥1)
- BORDER, 2, highlight border thickness in pixels
- HL_COLOR, 24'hFFD700, highlight colour
- KEY_COLOR, 24'hFF00FF, transparent key emitted outside the card
- FLASH_FRAMES, 30, frames per highlight on/off phase (≥1)

Derived widths:
- XW = $clog2(CARD_W+1)
- YW = $clog2(CARD_H+1)
- TW = $clog2(NUM_TYPES)
- NW = $clog2(NUM_GLYPHS+1)
- BAW = $clog2(NUM_TYPES·CARD_W·CARD_H)
- GAW = $clog2(NUM_GLYPHS·GLYPH_W·GLYPH_H)

Ports:
- vga_clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  request qualifier, one pixel per cycle
- x_pos  in  XW  card-local column
- y_pos  in  YW  card-local row
- card_type  in  TW  background select
- card_num  in  NW  glyph select
- selected  in  1  enable the highlight border
- dimmed  in  1  halve brightness
- frame_start  in  1  one-cycle pulse per frame
- bg_addr  out  BAW  background ROM address (combinational)
- bg_data  in  24  background ROM data, valid MEM_LAT cycles after the address
- glyph_addr  out  GAW  glyph ROM address (combinational)
- glyph_data  in  8  glyph ROM intensity, same latency as bg_data
- out_valid  out  1  output pixel qualifier
- out_data  out  24  composed RGB888 pixel

## Operation
- in_card = x_pos < CARD_W && y_pos < CARD_H.
- bg_addr = card_type·CARD_W·CARD_H + y_pos·CARD_W + x_pos when pix_valid && in_card; otherwise 0.
- in_glyph = in_card && GLYPH_X0 ≤ x < GLYPH_X0+GLYPH_W && GLYPH_Y0 ≤ y < GLYPH_Y0+GLYPH_H && card_num < NUM_GLYPHS && card_type ≤ OVERLAY_TYPE_MAX.
- glyph_addr = card_num·GLYPH_W·GLYPH_H + (y−GLYPH_Y0)·GLYPH_W + (x−GLYPH_X0) when in_glyph; otherwise 0.
- All address arithmetic is done at full width before truncation. No negative intermediates are allowed.
- Side-band delay line of depth MEM_LAT carries: pix_valid, in_card, in_glyph, border flag, selected, dimmed.
  - border flag = x < BORDER || x ≥ CARD_W−BORDER || y < BORDER || y ≥ CARD_H−BORDER.
  - Every decision uses delayed side-band only. No live input is sampled at compose time.
- Compose, in the MEM_LAT stage, per channel c ∈ {R,G,B}:
  1. s = bg_c + glyph_data, saturated to 255, if in_glyph && glyph_data ≠ 0; otherwise s = bg_c.
  2. If dimmed, s = s >> 1.
  3. If selected && border && flash_on, the pixel is HL_COLOR. Otherwise it is {sR,sG,sB}.
  4. If !in_card, the pixel is KEY_COLOR. This overrides every step above.
- The composed pixel and delayed pix_valid are registered into out_data and out_valid.
- out_data holds its last value when out_valid=0.
- Flash sequencer:
  - frame counter fc runs 0..FLASH_FRAMES−1 and increments on frame_start.
  - When frame_start arrives with fc = FLASH_FRAMES−1, fc wraps to 0 and flash_on toggles.
  - flash_on is sampled at compose time, not request time. A toggle mid-frame is accepted.

## Timing
- Latency: pix_valid at cycle t gives out_valid at t+MEM_LAT+1. Throughput is 1 pixel/cycle with no stalls.
- Reset (async assert, sync deassert by the parent):
  - out_valid=0, out_data=24'h0.
  - The side-band delay line is cleared to 0.
  - fc=0, flash_on=1.
- Reset mid-stream: in-flight pixels are discarded. out_valid is low from the assertion edge until MEM_LAT+1 cycles after the first valid post-reset request.
- frame_start coincident with pix_valid: both take effect. The toggle affects pixels composed on the next cycle onward.
- FLASH_FRAMES=1: flash_on toggles on every frame_start.
- Glyph sum overflow saturates per channel independently. Dimming applies after saturation.

## Test plan
- Background fetch: type=1, x=0, y=1 → bg_addr=3726, glyph_addr=0. ROM returns 0x123456 → out_data=0x123456 and out_valid exactly 3 cycles after the request.
- Glyph saturation: type=0, num=3, x=20, y=5 → glyph_addr=2754. bg=0x80F010, glyph=0x90 → out_data=0xFFFFA0.
- Overlay suppression: same as the glyph case with type=3, or with num=12 → glyph_addr=0 and out_data=bg.
- Dim: dimmed=1, bg=0x80F011, glyph=0 → 0x407808. Dim after saturation: case 2 with dimmed=1 → 0x7F7F50.
- Highlight and flash: selected=1 at x=1, y=30 → 0xFFD700. After 30 frame_start pulses → bg. After 60 → 0xFFD700. x=10, y=30 is never highlighted.
- Key and reset: x=54 → 0xFF00FF and bg_addr=0. Assert rst_n mid-stream → out_valid=0 immediately and flash restarts on.

Source files
------------

// File: rtl/card_pixel_renderer_if.sv
// card_pixel_renderer_if: request, ROM and pixel-output signals of the card renderer.
// Latency: none (wires only).
// Backpressure: none; the renderer accepts one pixel per cycle unconditionally.
// Ports: master = screen-region decoder / ROM / compositor side, slave = renderer.
interface card_pixel_renderer_if #(
  parameter int CARD_W     = 54,
  parameter int CARD_H     = 68,
  parameter int NUM_TYPES  = 4,
  parameter int NUM_GLYPHS = 10,
  parameter int GLYPH_W    = 22,
  parameter int GLYPH_H    = 40
);
  localparam int XW  = $clog2(CARD_W + 1);
  localparam int YW  = $clog2(CARD_H + 1);
  localparam int TW  = $clog2(NUM_TYPES);
  localparam int NW  = $clog2(NUM_GLYPHS + 1);
  localparam int BAW = $clog2(NUM_TYPES * CARD_W * CARD_H);
  localparam int GAW = $clog2(NUM_GLYPHS * GLYPH_W * GLYPH_H);

  // pixel request
  logic           pix_valid;
  logic [XW-1:0]  x_pos;
  logic [YW-1:0]  y_pos;
  logic [TW-1:0]  card_type;
  logic [NW-1:0]  card_num;
  logic           selected;
  logic           dimmed;
  logic           frame_start;
  // ROM ports
  logic [BAW-1:0] bg_addr;
  logic [23:0]    bg_data;
  logic [GAW-1:0] glyph_addr;
  logic [7:0]     glyph_data;
  // composed pixel
  logic           out_valid;
  logic [23:0]    out_data;

  modport master (
    output pix_valid, x_pos, y_pos, card_type, card_num, selected, dimmed,
           frame_start, bg_data, glyph_data,
    input  bg_addr, glyph_addr, out_valid, out_data
  );

  modport slave (
    input  pix_valid, x_pos, y_pos, card_type, card_num, selected, dimmed,
           frame_start, bg_data, glyph_data,
    output bg_addr, glyph_addr, out_valid, out_data
  );
endinterface

// File: rtl/card_pixel_renderer.sv
// card_pixel_renderer: per-pixel card renderer (background + glyph overlay + dim + flashing border).
// Latency: pix_valid at cycle t -> out_valid at t+MEM_LAT+1; ROM addresses are combinational.
// Backpressure: none, 1 pixel/cycle, never stalls.
// Ports: vga_clk, rst_n (async active-low), bus (slave modport: request, ROM addr/data, pixel out).
module card_pixel_renderer #(
  parameter int          CARD_W           = 54,
  parameter int          CARD_H           = 68,
  parameter int          NUM_TYPES        = 4,
  parameter int          GLYPH_W          = 22,
  parameter int          GLYPH_H          = 40,
  parameter int          GLYPH_X0         = 16,
  parameter int          GLYPH_Y0         = 0,
  parameter int          NUM_GLYPHS       = 10,
  parameter int          OVERLAY_TYPE_MAX = 2,
  parameter int          MEM_LAT          = 2,
  parameter int          BORDER           = 2,
  parameter logic [23:0] HL_COLOR         = 24'hFFD700,
  parameter logic [23:0] KEY_COLOR        = 24'hFF00FF,
  parameter int          FLASH_FRAMES     = 30
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  card_pixel_renderer_if.slave bus
);
  localparam int BAW = $clog2(NUM_TYPES * CARD_W * CARD_H);
  localparam int GAW = $clog2(NUM_GLYPHS * GLYPH_W * GLYPH_H);
  localparam int FCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  // side-band carried alongside the ROM read
  typedef struct packed {
    logic vld;
    logic in_card;
    logic in_glyph;
    logic border;
    logic sel;
    logic dim;
  } sb_t;

  // ---------------------------------------------------------------------------
  // request stage: address generation and side-band classification
  // ---------------------------------------------------------------------------
  int   xi, yi, ti, ni;
  int   bg_full, gl_full;
  logic in_card, in_glyph, border;
  sb_t  sb_in;

  always_comb begin
    // widen to int so all arithmetic happens before truncation
    xi = int'(bus.x_pos);
    yi = int'(bus.y_pos);
    ti = int'(bus.card_type);
    ni = int'(bus.card_num);

    in_card  = (xi < CARD_W) && (yi < CARD_H);
    in_glyph = in_card &&
               (xi >= GLYPH_X0) && (xi < GLYPH_X0 + GLYPH_W) &&
               (yi >= GLYPH_Y0) && (yi < GLYPH_Y0 + GLYPH_H) &&
               (ni < NUM_GLYPHS) && (ti <= OVERLAY_TYPE_MAX);
    border   = (xi < BORDER) || (xi >= CARD_W - BORDER) ||
               (yi < BORDER) || (yi >= CARD_H - BORDER);

    bg_full = 0;
    if (bus.pix_valid && in_card)
      bg_full = ti * CARD_W * CARD_H + yi * CARD_W + xi;

    // offsets are only formed inside the glyph window, so they are never negative
    gl_full = 0;
    if (in_glyph)
      gl_full = ni * GLYPH_W * GLYPH_H + (yi - GLYPH_Y0) * GLYPH_W + (xi - GLYPH_X0);

    sb_in.vld      = bus.pix_valid;
    sb_in.in_card  = in_card;
    sb_in.in_glyph = in_glyph;
    sb_in.border   = border;
    sb_in.sel      = bus.selected;
    sb_in.dim      = bus.dimmed;
  end

  assign bus.bg_addr    = BAW'(bg_full);
  assign bus.glyph_addr = GAW'(gl_full);

  // ---------------------------------------------------------------------------
  // side-band delay line, aligned with the ROM read latency
  // ---------------------------------------------------------------------------
  sb_t sb_pipe [MEM_LAT];

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) sb_pipe[i] <= '0;
    end else begin
      sb_pipe[0] <= sb_in;
      for (int i = 1; i < MEM_LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // flash sequencer
  // ---------------------------------------------------------------------------
  logic [FCW-1:0] fc;
  logic           flash_on;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      fc       <= '0;
      flash_on <= 1'b1;
    end else if (bus.frame_start) begin
      if (fc == FCW'(FLASH_FRAMES - 1)) begin
        fc       <= '0;
        flash_on <= ~flash_on;
      end else begin
        fc <= fc + FCW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // compose stage: only delayed side-band and the ROM data are looked at here
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  sb_t         sb_d;
  logic [23:0] shade;
  logic [23:0] pix;

  always_comb begin
    sb_d  = sb_pipe[MEM_LAT-1];
    shade = bus.bg_data;
    if (sb_d.in_glyph && (bus.glyph_data != 8'h00))
      shade = {sat_add(bus.bg_data[23:16], bus.glyph_data),
               sat_add(bus.bg_data[15:8],  bus.glyph_data),
               sat_add(bus.bg_data[7:0],   bus.glyph_data)};
    // per-channel halve: the LSB of each channel must not leak into its neighbour
    if (sb_d.dim)
      shade = {1'b0, shade[23:17], 1'b0, shade[15:9], 1'b0, shade[7:1]};

    if (sb_d.sel && sb_d.border && flash_on)
      pix = HL_COLOR;
    else
      pix = shade;

    if (!sb_d.in_card)
      pix = KEY_COLOR;
  end

  logic        out_valid_q;
  logic [23:0] out_data_q;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 24'h0;
    end else begin
      out_valid_q <= sb_d.vld;
      if (sb_d.vld) out_data_q <= pix;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_card_pixel_renderer.sv
// tb_card_pixel_renderer: directed + random stimulus with a scoreboard queue for card_pixel_renderer.
// Latency: checks out_valid/out_data MEM_LAT+1 cycles after each request.
// Backpressure: none; ROM data is replayed MEM_LAT cycles after each request.
module tb_card_pixel_renderer;
  localparam int          CARD_W = 54, CARD_H = 68, NUM_TYPES = 4;
  localparam int          GLYPH_W = 22, GLYPH_H = 40, GLYPH_X0 = 16, GLYPH_Y0 = 0;
  localparam int          NUM_GLYPHS = 10, OVERLAY_TYPE_MAX = 2, MEM_LAT = 2;
  localparam int          BORDER = 2, FLASH_FRAMES = 30;
  localparam logic [23:0] HL_COLOR = 24'hFFD700, KEY_COLOR = 24'hFF00FF;
  localparam int XW = $clog2(CARD_W + 1);
  localparam int YW = $clog2(CARD_H + 1);
  localparam int TW = $clog2(NUM_TYPES);
  localparam int NW = $clog2(NUM_GLYPHS + 1);

  logic vga_clk = 1'b0;
  logic rst_n;
  always #5 vga_clk = ~vga_clk;

  card_pixel_renderer_if #(
    .CARD_W(CARD_W), .CARD_H(CARD_H), .NUM_TYPES(NUM_TYPES),
    .NUM_GLYPHS(NUM_GLYPHS), .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H)
  ) bus ();

  card_pixel_renderer #(
    .CARD_W(CARD_W), .CARD_H(CARD_H), .NUM_TYPES(NUM_TYPES),
    .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H), .GLYPH_X0(GLYPH_X0), .GLYPH_Y0(GLYPH_Y0),
    .NUM_GLYPHS(NUM_GLYPHS), .OVERLAY_TYPE_MAX(OVERLAY_TYPE_MAX), .MEM_LAT(MEM_LAT),
    .BORDER(BORDER), .HL_COLOR(HL_COLOR), .KEY_COLOR(KEY_COLOR), .FLASH_FRAMES(FLASH_FRAMES)
  ) dut (
    .vga_clk(vga_clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int          x, y, t, n;
    logic        sel, dim;
    logic [23:0] bg;
    logic [7:0]  gl;
    int          due;
  } req_t;

  req_t        q[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0, fc_m = 0;
  logic        flash_m = 1'b1;
  logic        exp_vld;
  logic [23:0] exp_out, last_out = 24'h0;
  logic [23:0] rp_bg [MEM_LAT+1];
  logic [7:0]  rp_gl [MEM_LAT+1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'(a) + int'(b);
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  function automatic logic in_card_m(input int x, input int y);
    return (x < CARD_W) && (y < CARD_H);
  endfunction

  function automatic logic in_glyph_m(input int x, input int y, input int t, input int n);
    return in_card_m(x, y) && x >= GLYPH_X0 && x < GLYPH_X0 + GLYPH_W &&
           y >= GLYPH_Y0 && y < GLYPH_Y0 + GLYPH_H && n < NUM_GLYPHS && t <= OVERLAY_TYPE_MAX;
  endfunction

  function automatic int exp_bg(input int x, input int y, input int t);
    return in_card_m(x, y) ? t * CARD_W * CARD_H + y * CARD_W + x : 0;
  endfunction

  function automatic int exp_gl(input int x, input int y, input int t, input int n);
    return in_glyph_m(x, y, t, n) ? n * GLYPH_W * GLYPH_H + (y - GLYPH_Y0) * GLYPH_W + (x - GLYPH_X0) : 0;
  endfunction

  function automatic logic [23:0] model_pix(input req_t r, input logic fl);
    logic [7:0] ch [3];
    logic       bor;
    if (!in_card_m(r.x, r.y)) return KEY_COLOR;
    ch[0] = r.bg[23:16]; ch[1] = r.bg[15:8]; ch[2] = r.bg[7:0];
    for (int c = 0; c < 3; c++) begin
      if (in_glyph_m(r.x, r.y, r.t, r.n) && r.gl != 8'h00) ch[c] = sat(ch[c], r.gl);
      if (r.dim) ch[c] = ch[c] / 8'd2;
    end
    bor = r.x < BORDER || r.x >= CARD_W - BORDER || r.y < BORDER || r.y >= CARD_H - BORDER;
    if (r.sel && bor && fl) return HL_COLOR;
    return {ch[0], ch[1], ch[2]};
  endfunction

  // one clock cycle: drive request + replayed ROM data, check addresses, then outputs after the edge
  task automatic step(input logic v, input int x, input int y, input int t, input int n,
                      input logic sel, input logic dim, input logic fs,
                      input logic [23:0] bg, input logic [7:0] gl);
    req_t r;
    bus.pix_valid   = v;
    bus.x_pos       = XW'(x);
    bus.y_pos       = YW'(y);
    bus.card_type   = TW'(t);
    bus.card_num    = NW'(n);
    bus.selected    = sel;
    bus.dimmed      = dim;
    bus.frame_start = fs;
    for (int i = MEM_LAT; i > 0; i--) begin
      rp_bg[i] = rp_bg[i-1];
      rp_gl[i] = rp_gl[i-1];
    end
    rp_bg[0] = v ? bg : 24'($urandom);
    rp_gl[0] = v ? gl : 8'($urandom);
    bus.bg_data    = rp_bg[MEM_LAT];
    bus.glyph_data = rp_gl[MEM_LAT];
    #1;
    if (v) begin
      check("bg_addr", 32'(bus.bg_addr), 32'(exp_bg(x, y, t)));
      check("glyph_addr", 32'(bus.glyph_addr), 32'(exp_gl(x, y, t, n)));
      r.x = x; r.y = y; r.t = t; r.n = n; r.sel = sel; r.dim = dim;
      r.bg = bg; r.gl = gl; r.due = cyc + MEM_LAT;
      q.push_back(r);
    end
    exp_vld = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r       = q.pop_front();
      exp_vld = 1'b1;
      exp_out = model_pix(r, flash_m);
    end
    @(posedge vga_clk);
    if (fs) begin
      if (fc_m == FLASH_FRAMES - 1) begin
        fc_m    = 0;
        flash_m = !flash_m;
      end else begin
        fc_m++;
      end
    end
    cyc++;
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(exp_vld));
    if (exp_vld) begin
      check("out_data", 32'(bus.out_data), 32'(exp_out));
      last_out = exp_out;
    end else begin
      check("out_data_hold", 32'(bus.out_data), 32'(last_out));
    end
  endtask

  task automatic idle(input int cycles, input logic fs);
    for (int i = 0; i < cycles; i++) step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, fs, 24'h0, 8'h0);
  endtask

  task automatic apply_reset();
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    q.delete();
    flash_m  = 1'b1;
    fc_m     = 0;
    last_out = 24'h0;
    repeat (2) @(posedge vga_clk);
    #1;
    check("rst_hold_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       rs, rd, rf;
    logic [23:0] rbg;
    logic [7:0]  rgl;
    rst_n           = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.x_pos       = '0;
    bus.y_pos       = '0;
    bus.card_type   = '0;
    bus.card_num    = '0;
    bus.selected    = 1'b0;
    bus.dimmed      = 1'b0;
    bus.frame_start = 1'b0;
    bus.bg_data     = '0;
    bus.glyph_data  = '0;
    for (int i = 0; i <= MEM_LAT; i++) begin
      rp_bg[i] = '0;
      rp_gl[i] = '0;
    end
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'h0);
    check("reset_out_data", 32'(bus.out_data), 32'h0);
    rst_n = 1'b1;
    idle(2, 1'b0);

    // background fetch: bg_addr 3726, pixel 3 cycles later
    step(1'b1, 0, 1, 1, 0, 1'b0, 1'b0, 1'b0, 24'h123456, 8'h00);
    idle(4, 1'b0);
    // glyph saturation, overlay suppression by type and by glyph number, dimming
    step(1'b1, 20, 5, 0, 3,  1'b0, 1'b0, 1'b0, 24'h80F010, 8'h90);
    step(1'b1, 20, 5, 3, 3,  1'b0, 1'b0, 1'b0, 24'h80F010, 8'h90);
    step(1'b1, 20, 5, 0, 12, 1'b0, 1'b0, 1'b0, 24'h80F010, 8'h90);
    step(1'b1, 10, 30, 0, 0, 1'b0, 1'b1, 1'b0, 24'h80F011, 8'h00);
    step(1'b1, 20, 5, 0, 3,  1'b0, 1'b1, 1'b0, 24'h80F010, 8'h90);
    // key colour outside card, glyph window edges
    step(1'b1, 54, 10, 0, 0, 1'b0, 1'b0, 1'b0, 24'h111111, 8'h20);
    step(1'b1, 5, 68, 0, 0,  1'b0, 1'b0, 1'b0, 24'h222222, 8'h20);
    step(1'b1, 15, 10, 2, 9, 1'b0, 1'b0, 1'b0, 24'h010203, 8'h40);
    step(1'b1, 37, 39, 2, 9, 1'b0, 1'b0, 1'b0, 24'h010203, 8'h40);
    step(1'b1, 37, 40, 2, 9, 1'b0, 1'b0, 1'b0, 24'h010203, 8'h40);
    step(1'b1, 38, 10, 2, 9, 1'b0, 1'b0, 1'b0, 24'h010203, 8'h40);
    // highlight border
    step(1'b1, 1, 30, 1, 0,  1'b1, 1'b0, 1'b0, 24'h336699, 8'h00);
    step(1'b1, 10, 30, 1, 0, 1'b1, 1'b0, 1'b0, 24'h336699, 8'h00);
    step(1'b1, 52, 30, 1, 0, 1'b1, 1'b0, 1'b0, 24'h336699, 8'h00);
    step(1'b1, 51, 30, 1, 0, 1'b1, 1'b0, 1'b0, 24'h336699, 8'h00);
    step(1'b1, 30, 67, 1, 0, 1'b1, 1'b1, 1'b0, 24'h336699, 8'h00);
    idle(4, 1'b0);

    // 30 frames: flash off
    idle(30, 1'b1);
    step(1'b1, 1, 30, 1, 0, 1'b1, 1'b0, 1'b0, 24'h445566, 8'h00);
    idle(4, 1'b0);
    // 29 more frames, the 60th coincides with the request: composed with flash back on
    idle(29, 1'b1);
    step(1'b1, 1, 30, 1, 0, 1'b1, 1'b0, 1'b1, 24'h445566, 8'h00);
    idle(4, 1'b0);

    // flash off again, then reset with pixels in flight
    idle(30, 1'b1);
    step(1'b1, 1, 1, 0, 0, 1'b1, 1'b0, 1'b0, 24'h0A0B0C, 8'h00);
    step(1'b1, 2, 2, 0, 0, 1'b1, 1'b0, 1'b0, 24'h0A0B0C, 8'h00);
    step(1'b1, 3, 3, 0, 0, 1'b1, 1'b0, 1'b0, 24'h0A0B0C, 8'h00);
    apply_reset();
    idle(3, 1'b0);
    step(1'b1, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 24'h777777, 8'h00);
    idle(4, 1'b0);

    // random back-to-back stream with occasional frame pulses
    for (int i = 0; i < 60; i++) begin
      rs  = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      rf  = ($urandom_range(0, 3) == 0);
      rbg = 24'($urandom);
      rgl = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 4) != 0), int'($urandom_range(0, 56)), int'($urandom_range(0, 70)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 11)), rs, rd, rf, rbg, rgl);
    end
    idle(4, 1'b0);
    check("scoreboard_empty", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
